fft_bfly_sequencer: RTL and testbench

Control block for the in-place iterative radix-2 64-point FFT core. Once the input router has written a frame into the working buffer in bit-reversed order, this block issues butterfly operations one per cycle: the two buffer addresses and the twiddle index. It runs all LOG2_N stages in order and inserts drain gaps so that no stage reads data the previous stage has not yet written back. When the frame is finished it signals completion.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_bfly_addr_gen.sv | 31 +++
 rtl/fft_bfly_sequencer.sv | 138 +++++++++++++
 tb/tb_fft_bfly_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 FFT core control path.
package fft_pkg;

  localparam int unsigned N_POINTS         = 64;
  localparam int unsigned LOG2_N           = 6;
  localparam int unsigned BFLY_LAT_DEFAULT = 3;

  localparam int unsigned STAGE_W = 3;
  localparam int unsigned J_W     = LOG2_N - 1;
  localparam int unsigned TW_W    = LOG2_N - 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fft_seq_state_t;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational map from (stage, butterfly index) to the two in-place buffer
// addresses and the twiddle ROM index.
module fft_bfly_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] s,
  input  logic [J_W-1:0]     j,
  output logic [LOG2_N-1:0]  addr_a,
  output logic [LOG2_N-1:0]  addr_b,
  output logic [TW_W-1:0]    tw_idx
);

  logic [LOG2_N-1:0] j_ext;
  logic [LOG2_N-1:0] span;
  logic [LOG2_N-1:0] pos;
  logic [LOG2_N-1:0] grp;
  logic [LOG2_N-1:0] base;

  // Group index spreads out by two spans; position within the group is kept.
  always_comb begin
    j_ext  = LOG2_N'(j);
    span   = LOG2_N'(1) << s;
    pos    = j_ext & (span - LOG2_N'(1));
    grp    = j_ext >> s;
    base   = (grp << (s + STAGE_W'(1))) | pos;
    addr_a = base;
    addr_b = base + span;
    tw_idx = TW_W'(pos << (STAGE_W'(LOG2_N - 1) - s));
  end

endmodule

// File: rtl/fft_bfly_sequencer.sv
// Butterfly issue sequencer for the in-place 64-point radix-2 FFT.
// Optional per-stage output halving: define FFT_BFLY_SEQ_SCALE_EN.
module fft_bfly_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned BFLY_LAT = BFLY_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               bfly_valid,
  input  logic               bfly_ready,
  output logic [LOG2_N-1:0]  addr_a,
  output logic [LOG2_N-1:0]  addr_b,
  output logic [TW_W-1:0]    tw_idx,
  output logic [STAGE_W-1:0] stage
`ifdef FFT_BFLY_SEQ_SCALE_EN
  ,
  output logic               scale_en
`endif
);

  localparam int unsigned CNT_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [J_W-1:0]     J_LAST = J_W'(N_POINTS / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_N - 1);

  fft_seq_state_t     state_q, state_d;
  logic [STAGE_W-1:0] s_q, s_d;
  logic [J_W-1:0]     j_q, j_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LOG2_N-1:0]  gen_a, gen_b;
  logic [TW_W-1:0]    gen_tw;
  logic               handshake;

  assign handshake = bfly_valid & bfly_ready;

  // Addresses are generated for the next (s, j) so they can be registered.
  fft_bfly_addr_gen u_addr_gen (
    .s      (s_d),
    .j      (j_d),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          j_d     = '0;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (j_q == J_LAST) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(BFLY_LAT - 1);
          end else begin
            j_d = j_q + J_W'(1);
          end
        end
      end
      // Wait for the last butterfly of the stage to be written back.
      DRAIN: begin
        if (cnt_q == '0) begin
          if (s_q < S_LAST) begin
            state_d = ISSUE;
            s_d     = s_q + STAGE_W'(1);
            j_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      bfly_valid <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      tw_idx     <= '0;
      stage      <= '0;
`ifdef FFT_BFLY_SEQ_SCALE_EN
      scale_en   <= 1'b0;
`endif
    end else begin
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
      bfly_valid <= (state_d == ISSUE);
`ifdef FFT_BFLY_SEQ_SCALE_EN
      scale_en   <= (state_d == ISSUE);
`endif
      if (state_d == ISSUE) begin
        addr_a <= gen_a;
        addr_b <= gen_b;
        tw_idx <= gen_tw;
        stage  <= s_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Scoreboard bench for fft_bfly_sequencer: full frames, stalls, restart, abort.
module tb_fft_bfly_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bfly_ready;
  logic       busy;
  logic       done;
  logic       bfly_valid;
  logic [5:0] addr_a;
  logic [5:0] addr_b;
  logic [4:0] tw_idx;
  logic [2:0] stage;
`ifdef FFT_BFLY_SEQ_SCALE_EN
  logic       scale_en;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  fft_bfly_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bfly_valid (bfly_valid),
    .bfly_ready (bfly_ready),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .tw_idx     (tw_idx),
    .stage      (stage)
`ifdef FFT_BFLY_SEQ_SCALE_EN
    ,
    .scale_en   (scale_en)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected issue order: groups of 2*span entries, positions within a group in order.
  task automatic load_model();
    int span, a, b, tw;
    exp_q.delete();
    for (int s = 0; s < 6; s++) begin
      span = 1 << s;
      for (int g = 0; g < 32 / span; g++) begin
        for (int p = 0; p < span; p++) begin
          a  = g * 2 * span + p;
          b  = a + span;
          tw = p * (32 / span);
          exp_q.push_back({3'(s), 6'(a), 6'(b), 5'(tw)});
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(busy),       0);
    check({tag, "_done"},   32'(done),       0);
    check({tag, "_valid"},  32'(bfly_valid), 0);
    check({tag, "_addr_a"}, 32'(addr_a),     0);
    check({tag, "_addr_b"}, 32'(addr_b),     0);
    check({tag, "_tw_idx"}, 32'(tw_idx),     0);
    check({tag, "_stage"},  32'(stage),      0);
`ifdef FFT_BFLY_SEQ_SCALE_EN
    check({tag, "_scale_en"}, 32'(scale_en), 0);
`endif
  endtask

  // Start a frame in the current cycle (cycle 0) and follow it to done or abort point.
  task automatic run_frame(input int stall_pct, input bit hold_start, input int abort_hs,
                           output int done_cyc, output int stalls, output int hs);
    logic [63:0] cov[6];
    int          cov_n[6];
    logic [19:0] o, e;
    logic [20:0] held;
    bit          was_stalled;
    load_model();
    for (int i = 0; i < 6; i++) begin
      cov[i]   = '0;
      cov_n[i] = 0;
    end
    cyc         = 0;
    stalls      = 0;
    hs          = 0;
    done_cyc    = -1;
    was_stalled = 1'b0;
    held        = '0;
    start       = 1'b1;
    bfly_ready  = 1'b1;
    while (cyc < 3000) begin
      step();
      if (!hold_start) start = 1'b0;
      o = {stage, addr_a, addr_b, tw_idx};
      if (cyc == 1) begin
        check("first_valid", 32'(bfly_valid), 1);
        check("busy_rise", 32'(busy), 1);
      end
      if (was_stalled) check("stall_hold", 32'({bfly_valid, o}), 32'(held));
`ifdef FFT_BFLY_SEQ_SCALE_EN
      check("scale_en_track", 32'(scale_en), 32'(bfly_valid));
`endif
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_hs >= 0 && hs == abort_hs && bfly_valid) return;
      bfly_ready  = ($urandom_range(99) >= 32'(stall_pct));
      was_stalled = bfly_valid && !bfly_ready;
      held        = {bfly_valid, o};
      if (bfly_valid && bfly_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("issue", 32'(o), 32'(e));
        if (hs == 69) begin
          check("s2j5_a",  32'(addr_a), 9);
          check("s2j5_b",  32'(addr_b), 13);
          check("s2j5_tw", 32'(tw_idx), 8);
        end
        if (hs == 161) begin
          check("s5j1_a",  32'(addr_a), 1);
          check("s5j1_b",  32'(addr_b), 33);
          check("s5j1_tw", 32'(tw_idx), 1);
        end
        if (stage < 6) begin
          cov[stage][addr_a] = 1'b1;
          cov[stage][addr_b] = 1'b1;
          cov_n[stage] += 2;
        end
        hs++;
      end else if (bfly_valid) begin
        stalls++;
      end
    end
    if (done_cyc < 0) begin
      check("done_timeout", 32'(done), 1);
    end else begin
      check("done_cycle", 32'(done_cyc), 32'(211 + stalls));
      check("handshakes", 32'(hs), 192);
      check("queue_empty", 32'(exp_q.size()), 0);
      for (int i = 0; i < 6; i++) begin
        check("stage_cover", 32'(cov[i] == '1), 1);
        check("stage_cover_n", 32'(cov_n[i]), 64);
      end
    end
  endtask

  initial begin
    int dc, st, hs;
    rst        = 1'b1;
    start      = 1'b0;
    bfly_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 0);

    // Frame with start held high throughout; must not restart mid-frame.
    run_frame(0, 1'b1, -1, dc, st, hs);
    step();
    check("busy_fall", 32'(busy), 0);
    check("done_pulse", 32'(done), 0);

    // start is still high in the cycle busy falls: a new frame begins.
    run_frame(0, 1'b0, -1, dc, st, hs);
    step();
    check("busy_fall2", 32'(busy), 0);

    // Random backpressure.
    step();
    run_frame(30, 1'b0, -1, dc, st, hs);
    check("stalls_seen", 32'(st > 0), 1);
    step();
    step();

    // Abort at s=3, j=10.
    run_frame(0, 1'b0, 106, dc, st, hs);
    check("abort_stage", 32'(stage), 3);
    check("abort_addr_a", 32'(addr_a), 18);
    check("abort_addr_b", 32'(addr_b), 26);
    check("abort_tw", 32'(tw_idx), 8);
    rst = 1'b1;
    step();
    check_reset_outputs("abort");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_done_after_abort", 32'({busy, done}), 0);
    end
    run_frame(0, 1'b0, -1, dc, st, hs);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
